// File: rtl/sync_bidir_fifo_pkg.sv
// Shared types and constants for the bidirectional FIFO: FSM state
// encoding and the meaning of the dir output.
package sync_bidir_fifo_pkg;

  typedef enum logic [1:0] {
    A2B      = 2'd0,
    TURN_B2A = 2'd1,
    B2A      = 2'd2,
    TURN_A2B = 2'd3
  } state_e;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

endpackage

// File: rtl/sync_bidir_fifo_ram.sv
// Single-clock storage array for the bidirectional FIFO: one synchronous
// write port, one asynchronous read port.
module sync_bidir_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem_q [0:(1<<ASIZE)-1];

  // Write port: store the accepted word at the write pointer.
  // NOTE: the array has no reset; stale contents are never visible because
  // count gates every read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_bidir_fifo.sv
// Bidirectional single-clock FIFO shared by ports A and B. dir selects the
// writer (A when 1) and the reader (B when 1); a turnaround drains the FIFO
// before the direction flips. Optional macro SYNC_BIDIR_FIFO_FWFT_EN makes
// the reader's rdata show the head word combinationally (first-word
// fall-through); otherwise rdata is registered on each accepted read.
module sync_bidir_fifo
  import sync_bidir_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_req,
  output logic             dir,
  output logic             busy,
  input  logic             a_winc,
  input  logic [DSIZE-1:0] a_wdata,
  input  logic             a_rinc,
  output logic [DSIZE-1:0] a_rdata,
  output logic             a_full,
  output logic             a_afull,
  output logic             a_empty,
  output logic             a_aempty,
  input  logic             b_winc,
  input  logic [DSIZE-1:0] b_wdata,
  input  logic             b_rinc,
  output logic [DSIZE-1:0] b_rdata,
  output logic             b_full,
  output logic             b_afull,
  output logic             b_empty,
  output logic             b_aempty,
  output logic [ASIZE:0]   count
);

  localparam logic [ASIZE:0] DEPTH_W    = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_LVL  = DEPTH_W - (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_TH);

  state_e           state_q, state_d;
  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic [DSIZE-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic             lvl_full, lvl_afull, lvl_empty, lvl_aempty;
  logic             wr_open, wr_inc, rd_inc, wr_en, rd_en;
  logic [DSIZE-1:0] wr_data, ram_rdata;

  assign dir  = (state_q == A2B || state_q == TURN_B2A) ? DIR_A2B : DIR_B2A;
  assign busy = (state_q == TURN_B2A || state_q == TURN_A2B);

  assign lvl_full   = (count_q == DEPTH_W);
  assign lvl_empty  = (count_q == '0);
  assign lvl_afull  = (count_q >= AFULL_LVL);
  assign lvl_aempty = (count_q <= AEMPTY_LVL);

  // The writer is blocked for the whole turnaround; the reader keeps draining.
  assign wr_open = !busy;
  assign wr_inc  = (dir == DIR_A2B) ? a_winc  : b_winc;
  assign wr_data = (dir == DIR_A2B) ? a_wdata : b_wdata;
  assign rd_inc  = (dir == DIR_A2B) ? b_rinc  : a_rinc;
  assign wr_en   = wr_inc && wr_open && !lvl_full;
  assign rd_en   = rd_inc && !lvl_empty;

  assign a_full   = (dir == DIR_A2B && wr_open) ? lvl_full  : 1'b1;
  assign a_afull  = (dir == DIR_A2B && wr_open) ? lvl_afull : 1'b1;
  assign b_full   = (dir == DIR_B2A && wr_open) ? lvl_full  : 1'b1;
  assign b_afull  = (dir == DIR_B2A && wr_open) ? lvl_afull : 1'b1;
  assign a_empty  = (dir == DIR_B2A) ? lvl_empty  : 1'b1;
  assign a_aempty = (dir == DIR_B2A) ? lvl_aempty : 1'b1;
  assign b_empty  = (dir == DIR_A2B) ? lvl_empty  : 1'b1;
  assign b_aempty = (dir == DIR_A2B) ? lvl_aempty : 1'b1;
  assign count    = count_q;

  sync_bidir_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wr_data),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  // Direction FSM: start a turnaround on request, abort it if the request
  // reverts, and flip direction once the FIFO has drained.
  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A2B:      if (dir_req == DIR_B2A) state_d = TURN_B2A;
      TURN_B2A: if (dir_req == DIR_A2B) state_d = A2B;
                else if (lvl_empty)     state_d = B2A;
      B2A:      if (dir_req == DIR_A2B) state_d = TURN_A2B;
      TURN_A2B: if (dir_req == DIR_B2A) state_d = B2A;
                else if (lvl_empty)     state_d = A2B;
      default:  state_d = A2B;
    endcase
  end

  // Pointer, fill-level and read-data updates for accepted accesses.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (wr_en) wptr_d = wptr_q + ASIZE'(1);
    if (rd_en) begin
      rptr_d = rptr_q + ASIZE'(1);
      if (dir == DIR_A2B) b_rdata_d = ram_rdata;
      else                a_rdata_d = ram_rdata;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (ASIZE+1)'(1);
      2'b01:   count_d = count_q - (ASIZE+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= A2B;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

`ifdef SYNC_BIDIR_FIFO_FWFT_EN
  // The reader sees the head word as soon as one is stored; otherwise the
  // last word it consumed.
  assign a_rdata = (dir == DIR_B2A && !lvl_empty) ? ram_rdata : a_rdata_q;
  assign b_rdata = (dir == DIR_A2B && !lvl_empty) ? ram_rdata : b_rdata_q;
`else
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
`endif

endmodule
